// File: rtl/pair_pkg.sv
// Shared types and state encodings for the pair_packer stream stage.
package pair_pkg;

  typedef struct packed {
    byte x;
    byte y;
  } byte_pair_t;

  // State is {hold_valid, out_valid}.
  localparam logic [1:0] ST_EMPTY     = 2'b00;
  localparam logic [1:0] ST_HALF      = 2'b10;
  localparam logic [1:0] ST_PAIR      = 2'b01;
  localparam logic [1:0] ST_PAIR_HALF = 2'b11;

endpackage : pair_pkg

// File: rtl/pair_out_reg.sv
// Single-entry valid/ready output register. A load takes precedence over a
// drain in the same cycle, so a back-to-back pair keeps o_valid high.
module pair_out_reg
  import pair_pkg::*;
#(
  parameter type T = byte_pair_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  T     i_data,
  input  logic i_ready,
  output logic o_valid,
  output T     o_data
);

  logic r_valid;
  T     r_data;

  // Load a new entry, otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      // NOTE: data is reset too so out_data reads a defined '0 after reset.
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : pair_out_reg

// File: rtl/pair_packer.sv
// Packs consecutive stream elements into {x, y} pairs, x = first element.
// Optional feature: define PAIR_PACKER_FLUSH_EN to add the flush port, which
// emits a held lone x padded with PAD in y.
module pair_packer
  import pair_pkg::*;
#(
  parameter type T      = byte,
  parameter T    PAD    = '0,
  parameter type PAIR_T = struct packed { T x, y; }
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  T      in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output PAIR_T out_data
`ifdef PAIR_PACKER_FLUSH_EN
  ,
  input  logic  flush
`endif
);

  if ($bits(PAIR_T) != 2 * $bits(T)) begin : g_width_check
    $error("pair_packer: PAIR_T must be exactly twice the width of T");
  end

  logic       r_hold_valid;
  T           r_hold_q;
  logic       w_out_valid;
  logic [1:0] w_state;
  logic       w_in_hs;
  logic       w_pair_load;
  logic       w_flush_load;
  logic       w_load;
  T           w_y;
  PAIR_T      w_load_data;

  assign w_state  = {r_hold_valid, w_out_valid};
  // Only a stalled full pair plus a held x blocks the input.
  assign in_ready = !((w_state == ST_PAIR_HALF) && !out_ready);
  assign w_in_hs  = in_valid && in_ready;

  assign w_pair_load = w_in_hs && r_hold_valid;
`ifdef PAIR_PACKER_FLUSH_EN
  // An input handshake completes the pair normally and wins over flush.
  assign w_flush_load = flush && r_hold_valid && !w_in_hs
                        && (!w_out_valid || out_ready);
`else
  assign w_flush_load = 1'b0;
`endif
  assign w_load = w_pair_load || w_flush_load;

  assign w_y         = w_pair_load ? in_data : PAD;
  // x occupies the upper half of the packed pair.
  assign w_load_data = {r_hold_q, w_y};

  // Hold register: capture x on the first element, release on pair/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_q     <= '0;
    end else if (w_in_hs && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_q     <= in_data;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end
  end

  // The output register's type follows out_data (PAIR_T).
  pair_out_reg #(
    .T (PAIR_T)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_ready (out_ready),
    .o_valid (w_out_valid),
    .o_data  (out_data)
  );

  assign out_valid = w_out_valid;

endmodule : pair_packer

// File: doc/pair_packer.md
# pair_packer

Streaming stage that accepts a sequence of elements of a type parameter `T` and packs consecutive elements into a two-field packed struct `{x, y}` of the same element type. It sits directly upstream of the type-parameterised consumer whose pair type defaults to `struct packed { type(INDIRECT) x, y; }` and drives it with that struct. The first accepted element of a pair lands in `x`, and the second lands in `y`. Handshakes on both sides are valid/ready, and throughput is one element per cycle.

## Interface
- `T`, default `byte`: element type (type parameter).
- `PAD`, default `0`: value of type `T` that fills `y` on a flushed partial pair.
- `PAIR_T`, default `struct packed { T x, y; }`: output type (type parameter). Declared after `T` so the default resolves against the overridden `T`.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `in_valid`, input, 1: upstream element valid.
- `in_ready`, output, 1: element accepted when `in_valid && in_ready`.
- `in_data`, input, `$bits(T)`: element.
- `out_valid`, output, 1: pair valid.
- `out_ready`, input, 1: pair consumed when `out_valid && out_ready`.
- `out_data`, output, `$bits(PAIR_T)`: packed pair, with `x` in the upper half.
- `flush`, input, 1: present only with `PAIR_PACKER_FLUSH_EN`. Emits a held half-pair.

## Operation
- Holds two pieces of state:
  - hold register `hold_q`, with flag `hold_valid`, which stores the pending `x`;
  - single-entry output register `out_data` / `out_valid`.
- State encoding `{hold_valid, out_valid}` gives four states: EMPTY (00), HALF (10), PAIR (01), PAIR_HALF (11).
- `in_ready = !hold_valid || !out_valid || out_ready`. This is combinational from state and `out_ready`; it does not depend on `in_valid`.
- Accept when `hold_valid = 0`: `hold_q <= in_data` and `hold_valid <= 1`.
- Accept when `hold_valid = 1`:
  - `out_data <= {x: hold_q, y: in_data}`;
  - `out_valid <= 1`;
  - `hold_valid <= 0`.
- Output drain: `out_valid` clears on `out_ready` unless a new pair is loaded in the same cycle. A new pair loaded in the same cycle takes precedence, and `out_valid` stays 1.
- `out_data` holds its value whenever `out_valid && !out_ready`.
- Element order is preserved. No element is dropped or duplicated under any backpressure pattern.
- Reset values:
  - `hold_valid = 0`, `out_valid = 0`, `out_data = '0`, `hold_q = '0`;
  - `in_ready = 1` in the cycle after reset deasserts.
- Reset asserted mid-pair discards the held `x` and any undelivered pair.
- Width rule: `$bits(out_data) == 2*$bits(T)`. A non-default `PAIR_T` must satisfy this, enforced by an elaboration-time `$error`.

## Timing
- Latency: the pair appears on `out_data` with `out_valid = 1` in the cycle after the second element is accepted.
- Sustained rate: one element per cycle in and one pair per two cycles out, with `out_ready` held high.
- With `out_ready = 0` and state PAIR_HALF, `in_ready = 0`. `in_ready` rises combinationally in the same cycle `out_ready` rises.
- From EMPTY, at most three elements are accepted with `out_ready` held low. The first pair is then stalled in the output register and the third element is held in `x`.

## Configuration
- Macro: `PAIR_PACKER_FLUSH_EN`.
- Defined:
  - adds the `flush` port;
  - if `flush && hold_valid` and the output slot is free or draining, and no input handshake occurs that cycle, loads `{x: hold_q, y: PAD}` and clears `hold_valid`;
  - an input handshake in the same cycle has priority, so the pair completes normally and `flush` has no effect;
  - `flush` in EMPTY or PAIR has no effect;
  - `flush` is level-sensitive and stays pending until it can be taken.
- Undefined: no `flush` port. A lone held `x` waits indefinitely for its partner.

## Structure
- Package `pair_pkg`:
  - typedef `byte_pair_t` (`struct packed { byte x, y; }`);
  - localparam state encodings for EMPTY, HALF, PAIR and PAIR_HALF, used by assertions and the bench.
- One sub-module, `pair_out_reg`: a single-entry valid/ready register parameterised by `parameter type T`. It is instantiated with `type(out_data)`.
- The hold register and the flush logic stay in `pair_packer`.

## Test plan
- `T = byte`, `out_ready = 1`, inputs 0x11 then 0x22 on consecutive cycles -> one cycle after 0x22 is accepted, `out_valid = 1` and `out_data = 16'h1122`; the bench checks field `x = 0x11` and field `y = 0x22`.
- Continuous stream 0x00..0x07 with `out_ready` toggling every cycle -> pairs 0x0001, 0x0203, 0x0405, 0x0607 in order, none lost or duplicated; `in_ready` drops only in state PAIR_HALF with `out_ready = 0`.
- `out_ready = 0`, feed 0xA1, 0xA2, 0xA3, 0xA4 -> only three are accepted and `in_ready = 0` after the third; raising `out_ready` delivers 0xA1A2, then 0xA3A4.
- With `PAIR_PACKER_FLUSH_EN`, `PAD = 8'hFF`: feed 0x5A, then `flush` for one cycle -> `out_data = 16'h5AFF` on the next cycle. Repeating with `in_valid` carrying 0x6B in the flush cycle gives `16'h5A6B` instead.
- `rst` pulsed while HALF holds 0x33 -> after reset `out_valid = 0`; the next inputs 0x44, 0x55 give `16'h4455`, not containing 0x33.
- `T = logic [11:0]`, default `PAIR_T` -> `$bits(out_data) = 24`; inputs 12'hABC, 12'h123 give `24'hABC123`.
